// File: rtl/adc_lane_serializer_if.sv
// Per-channel beat stream from the lane serializer to the beamformer datapath.
// The serializer holds the master side; the consumer holds the slave side.
interface adc_lane_serializer_if #(
  parameter int IQ_WIDTH = 16,
  parameter int CH_W     = 5
);
  logic [IQ_WIDTH-1:0] out_i;
  logic [IQ_WIDTH-1:0] out_q;
  logic [CH_W-1:0]     out_ch;
  logic                out_sof;
  logic                out_eof;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_i, out_q, out_ch, out_sof, out_eof, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_i, out_q, out_ch, out_sof, out_eof, out_valid,
    output out_ready
  );
endinterface

// File: rtl/adc_lane_serializer.sv
// Captures lane-wide IQ frames into a ping-pong buffer and streams them out
// one channel per accepted beat, counting frames dropped for lack of space.
module adc_lane_serializer #(
  parameter int NUM_CH   = 24,
  parameter int IQ_WIDTH = 16,
  parameter int CH_W     = 5,
  parameter int CNT_W    = 16
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*2*IQ_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         enable,
  input  logic                         clear_stats,
  adc_lane_serializer_if.master        beat,
  output logic [CNT_W-1:0]             overflow_cnt,
  output logic                         overflow_sticky
);

  localparam int unsigned FW = NUM_CH * 2 * IQ_WIDTH;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              r_state;
  state_t              w_nxt_state;
  logic [FW-1:0]       r_buf0;
  logic [FW-1:0]       r_buf1;
  logic [1:0]          r_full;
  logic [1:0]          w_full_nxt;
  logic                r_wr_sel;
  logic                r_rd_sel;

  logic [IQ_WIDTH-1:0] r_out_i;
  logic [IQ_WIDTH-1:0] r_out_q;
  logic [CH_W-1:0]     r_out_ch;
  logic                r_out_sof;
  logic                r_out_eof;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_ovf_cnt;
  logic                r_ovf_sticky;

  logic                w_accept;
  logic                w_last_acc;
  logic                w_rel0;
  logic                w_rel1;
  logic                w_wr_free;
  logic                w_capture;
  logic                w_drop;

  logic                w_load;
  logic                w_load_sel;
  logic [CH_W-1:0]     w_load_ch;
  logic                w_go_idle;
  logic [FW-1:0]       w_src;
  logic [IQ_WIDTH-1:0] w_ld_i;
  logic [IQ_WIDTH-1:0] w_ld_q;

  // Handshake and buffer-release decode
  assign w_accept   = (r_state == STREAM) && r_out_valid && beat.out_ready;
  assign w_last_acc = w_accept && (r_out_ch == CH_W'(NUM_CH - 1));
  assign w_rel0     = w_last_acc && !r_rd_sel;
  assign w_rel1     = w_last_acc &&  r_rd_sel;

  // A buffer draining its last beat on this edge is reusable on the same edge
  assign w_wr_free = r_wr_sel ? (!r_full[1] || w_rel1) : (!r_full[0] || w_rel0);
  assign w_capture = enable && in_valid &&  w_wr_free;
  assign w_drop    = enable && in_valid && !w_wr_free;

  assign w_full_nxt[0] = (r_full[0] && !w_rel0) || (w_capture && !r_wr_sel);
  assign w_full_nxt[1] = (r_full[1] && !w_rel1) || (w_capture &&  r_wr_sel);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0   <= '0;
      r_buf1   <= '0;
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_capture) begin
        if (r_wr_sel) r_buf1 <= in_data;
        else          r_buf0 <= in_data;
        r_wr_sel <= ~r_wr_sel;
      end
      r_full <= w_full_nxt;
      if (w_last_acc) r_rd_sel <= ~r_rd_sel;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clear_stats) begin
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (w_drop) begin
      if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      r_ovf_sticky <= 1'b1;
    end
  end

  // Read FSM: state register
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  // Read FSM: next state (full flags as registered at cycle start)
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    if (r_full[r_rd_sel]) w_nxt_state = STREAM;
      STREAM:  if (w_last_acc && !r_full[~r_rd_sel]) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Read FSM: output-register load decisions
  always_comb begin
    w_load     = 1'b0;
    w_load_sel = r_rd_sel;
    w_load_ch  = '0;
    w_go_idle  = 1'b0;
    case (r_state)
      IDLE: if (r_full[r_rd_sel]) w_load = 1'b1;
      STREAM: begin
        if (w_last_acc) begin
          if (r_full[~r_rd_sel]) begin
            w_load     = 1'b1;
            w_load_sel = ~r_rd_sel;
          end else begin
            w_go_idle = 1'b1;
          end
        end else if (w_accept) begin
          w_load    = 1'b1;
          w_load_ch = r_out_ch + 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase
  end

  assign w_src = w_load_sel ? r_buf1 : r_buf0;

  always_comb begin
    w_ld_i = '0;
    w_ld_q = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_load_ch == CH_W'(c)) begin
        w_ld_i = w_src[c*2*IQ_WIDTH +: IQ_WIDTH];
        w_ld_q = w_src[c*2*IQ_WIDTH + IQ_WIDTH +: IQ_WIDTH];
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_ch    <= '0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_i     <= w_ld_i;
      r_out_q     <= w_ld_q;
      r_out_ch    <= w_load_ch;
      r_out_sof   <= (w_load_ch == '0);
      r_out_eof   <= (w_load_ch == CH_W'(NUM_CH - 1));
      r_out_valid <= 1'b1;
    end else if (w_go_idle) begin
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_ch    <= '0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_valid <= 1'b0;
    end
  end

  assign beat.out_i      = r_out_i;
  assign beat.out_q      = r_out_q;
  assign beat.out_ch     = r_out_ch;
  assign beat.out_sof    = r_out_sof;
  assign beat.out_eof    = r_out_eof;
  assign beat.out_valid  = r_out_valid;
  assign overflow_cnt    = r_ovf_cnt;
  assign overflow_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_adc_lane_serializer.sv
// Directed bench for adc_lane_serializer: latency, backpressure, ping-pong,
// overflow/clear, reset abort and counter saturation (second instance, CNT_W=4).
module tb_adc_lane_serializer;

  localparam int NC = 4;
  localparam int W  = 16;
  localparam int CW = 2;
  localparam int FW = NC * 2 * W;

  logic          adc_clk;
  logic          rst_n;
  logic [FW-1:0] in_data;
  logic          in_valid;
  logic          enable;
  logic          en_s;
  logic          clear_stats;
  logic [15:0]   ovf_cnt;
  logic          ovf_sticky;
  logic [3:0]    ovf_cnt_s;
  logic          ovf_sticky_s;

  int n_total = 0;
  int n_bad   = 0;
  int e;
  int p;

  adc_lane_serializer_if #(.IQ_WIDTH(W), .CH_W(CW)) if0 ();
  adc_lane_serializer_if #(.IQ_WIDTH(W), .CH_W(CW)) if_s ();

  adc_lane_serializer #(.NUM_CH(NC), .IQ_WIDTH(W), .CH_W(CW), .CNT_W(16)) dut (
    .adc_clk         (adc_clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .enable          (enable),
    .clear_stats     (clear_stats),
    .beat            (if0.master),
    .overflow_cnt    (ovf_cnt),
    .overflow_sticky (ovf_sticky)
  );

  adc_lane_serializer #(.NUM_CH(NC), .IQ_WIDTH(W), .CH_W(CW), .CNT_W(4)) dut_s (
    .adc_clk         (adc_clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .enable          (en_s),
    .clear_stats     (clear_stats),
    .beat            (if_s.master),
    .overflow_cnt    (ovf_cnt_s),
    .overflow_sticky (ovf_sticky_s)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [15:0] bi, input logic [15:0] bq);
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < NC; c++) begin
      f[c*2*W +: W]     = bi + 16'(c);
      f[c*2*W + W +: W] = bq + 16'(c);
    end
    return f;
  endfunction

  task automatic see_beat(input string tag, input int c, input logic [15:0] bi, input logic [15:0] bq);
    chk({tag, "_valid"}, if0.out_valid, 1);
    chk({tag, "_ch"},    if0.out_ch, c);
    chk({tag, "_i"},     if0.out_i, bi + 16'(c));
    chk({tag, "_q"},     if0.out_q, bq + 16'(c));
    chk({tag, "_sof"},   if0.out_sof, (c == 0));
    chk({tag, "_eof"},   if0.out_eof, (c == NC - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    enable      = 1'b0;
    en_s        = 1'b0;
    clear_stats = 1'b0;
    if0.out_ready  = 1'b0;
    if_s.out_ready = 1'b0;
    repeat (3) @(negedge adc_clk);
    rst_n = 1'b1;
    @(negedge adc_clk);

    chk("rst_valid",  if0.out_valid, 0);
    chk("rst_ch",     if0.out_ch, 0);
    chk("rst_i",      if0.out_i, 0);
    chk("rst_cnt",    ovf_cnt, 0);
    chk("rst_sticky", ovf_sticky, 0);

    // single frame, two-cycle latency
    in_data = mk(16'h1000, 16'h2000);
    in_valid = 1'b1;
    enable = 1'b1;
    if0.out_ready = 1'b1;
    @(negedge adc_clk);
    in_valid = 1'b0;
    chk("t1_latency", if0.out_valid, 0);
    for (int b = 0; b < NC; b++) begin
      @(negedge adc_clk);
      see_beat("t1", b, 16'h1000, 16'h2000);
    end
    @(negedge adc_clk);
    chk("t1_idle", if0.out_valid, 0);
    chk("t1_cnt",  ovf_cnt, 0);

    // backpressure, ready pattern 1,0,0,1
    in_data = mk(16'h3000, 16'h4000);
    in_valid = 1'b1;
    @(negedge adc_clk);
    in_valid = 1'b0;
    e = 0;
    p = 0;
    for (int k = 0; k < 40 && e < NC; k++) begin
      @(negedge adc_clk);
      if (if0.out_valid) begin
        see_beat("t2", e, 16'h3000, 16'h4000);
        if0.out_ready = ((p % 4) == 0) || ((p % 4) == 3);
        p++;
        if (if0.out_ready) e++;
      end
    end
    chk("t2_beats", e, NC);
    @(negedge adc_clk);
    chk("t2_idle", if0.out_valid, 0);
    if0.out_ready = 1'b1;

    // ping-pong, back-to-back frames
    in_data = mk(16'hA000, 16'hA800);
    in_valid = 1'b1;
    @(negedge adc_clk);
    in_data = mk(16'hB000, 16'hB800);
    chk("t3_latency", if0.out_valid, 0);
    @(negedge adc_clk);
    in_valid = 1'b0;
    for (int b = 0; b < 2*NC; b++) begin
      if (b > 0) @(negedge adc_clk);
      if (b < NC) see_beat("t3a", b, 16'hA000, 16'hA800);
      else        see_beat("t3b", b - NC, 16'hB000, 16'hB800);
    end
    @(negedge adc_clk);
    chk("t3_idle", if0.out_valid, 0);

    // overflow with consumer stalled
    if0.out_ready = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_data = mk(16'h5000 + 16'(j*256), 16'h6000 + 16'(j*256));
      @(negedge adc_clk);
    end
    in_valid = 1'b0;
    chk("t4_cnt",    ovf_cnt, 8);
    chk("t4_sticky", ovf_sticky, 1);
    chk("t4_hold_v", if0.out_valid, 1);
    chk("t4_hold_i", if0.out_i, 16'h5000);
    clear_stats = 1'b1;
    @(negedge adc_clk);
    clear_stats = 1'b0;
    chk("t4_clr_cnt",    ovf_cnt, 0);
    chk("t4_clr_sticky", ovf_sticky, 0);
    clear_stats = 1'b1;
    in_valid = 1'b1;
    @(negedge adc_clk);
    clear_stats = 1'b0;
    chk("t4_prio_cnt",    ovf_cnt, 0);
    chk("t4_prio_sticky", ovf_sticky, 0);
    @(negedge adc_clk);
    in_valid = 1'b0;
    chk("t4_drop1_cnt",    ovf_cnt, 1);
    chk("t4_drop1_sticky", ovf_sticky, 1);
    if0.out_ready = 1'b1;
    for (int b = 0; b < 2*NC; b++) begin
      if (b > 0) @(negedge adc_clk);
      if (b < NC) see_beat("t4f0", b, 16'h5000, 16'h6000);
      else        see_beat("t4f1", b - NC, 16'h5100, 16'h6100);
    end
    @(negedge adc_clk);
    chk("t4_idle", if0.out_valid, 0);

    // reset mid-stream, then disabled input
    in_data = mk(16'h7000, 16'h8000);
    in_valid = 1'b1;
    @(negedge adc_clk);
    in_valid = 1'b0;
    @(negedge adc_clk);
    see_beat("t5b0", 0, 16'h7000, 16'h8000);
    @(negedge adc_clk);
    see_beat("t5b1", 1, 16'h7000, 16'h8000);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", if0.out_valid, 0);
    chk("t5_rst_ch",    if0.out_ch, 0);
    chk("t5_rst_cnt",   ovf_cnt, 0);
    @(negedge adc_clk);
    rst_n = 1'b1;
    enable = 1'b0;
    in_valid = 1'b1;
    in_data = mk(16'h9000, 16'h9800);
    for (int k = 0; k < 6; k++) begin
      @(negedge adc_clk);
      chk("t5_dis_valid", if0.out_valid, 0);
    end
    chk("t5_dis_cnt",    ovf_cnt, 0);
    chk("t5_dis_sticky", ovf_sticky, 0);
    in_valid = 1'b0;
    @(negedge adc_clk);

    // saturation on the CNT_W=4 instance
    en_s = 1'b1;
    in_valid = 1'b1;
    repeat (16) @(negedge adc_clk);
    chk("t6_cnt14", ovf_cnt_s, 14);
    repeat (6) @(negedge adc_clk);
    chk("t6_sat",    ovf_cnt_s, 15);
    chk("t6_sticky", ovf_sticky_s, 1);
    en_s = 1'b0;
    in_valid = 1'b0;
    chk("t6_main_cnt", ovf_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
